// File: rtl/blk_1f839b.sv
// Two-requester m_axi write arbiter: round-robin AW grant, W routed in granted-AW order via an ID FIFO.
// Optional `WR_ARB_FIXED_PRIO_EN: s0 always wins an AW tie instead of round-robin.
module blk_1f839b #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MAXREQS    = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      clk_en,
    input  logic [ADDR_WIDTH-1:0]     s0_AWADDR,
    input  logic [7:0]                s0_AWLEN,
    input  logic                      s0_AWVALID,
    output logic                      s0_AWREADY,
    input  logic [DATA_WIDTH-1:0]     s0_WDATA,
    input  logic [DATA_WIDTH/8-1:0]   s0_WSTRB,
    input  logic                      s0_WLAST,
    input  logic                      s0_WVALID,
    output logic                      s0_WREADY,
    input  logic [ADDR_WIDTH-1:0]     s1_AWADDR,
    input  logic [7:0]                s1_AWLEN,
    input  logic                      s1_AWVALID,
    output logic                      s1_AWREADY,
    input  logic [DATA_WIDTH-1:0]     s1_WDATA,
    input  logic [DATA_WIDTH/8-1:0]   s1_WSTRB,
    input  logic                      s1_WLAST,
    input  logic                      s1_WVALID,
    output logic                      s1_WREADY,
    output logic [ADDR_WIDTH-1:0]     m_AWADDR,
    output logic [7:0]                m_AWLEN,
    output logic                      m_AWVALID,
    input  logic                      m_AWREADY,
    output logic [DATA_WIDTH-1:0]     m_WDATA,
    output logic [DATA_WIDTH/8-1:0]   m_WSTRB,
    output logic                      m_WLAST,
    output logic                      m_WVALID,
    input  logic                      m_WREADY,
    output logic [$clog2(MAXREQS):0]  pending
);
    localparam int PW = $clog2(MAXREQS) + 1;
    localparam int IW = (MAXREQS > 1) ? $clog2(MAXREQS) : 1;

    logic          rr_last_q, rr_last_d;
    logic          lock_q, lock_d;
    logic          locked_id_q, locked_id_d;
    logic          order_q [MAXREQS];
    logic          order_d [MAXREQS];
    logic [IW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] count_q, count_d;

    logic active, full, grant, aw_ok, aw_fire, head, w_ok, w_pop;

    function automatic logic [IW-1:0] ptr_next(input logic [IW-1:0] p);
        return (p == IW'(MAXREQS - 1)) ? '0 : p + 1'b1;
    endfunction

    assign pending = count_q;

    always_comb begin
        active = !reset && clk_en;
        full   = (count_q == PW'(MAXREQS));

        // A locked grant holds until its handshake so AXI VALID/ADDR stay stable.
        if (lock_q)
            grant = locked_id_q;
        else if (s0_AWVALID && s1_AWVALID)
`ifdef WR_ARB_FIXED_PRIO_EN
            grant = 1'b0;
`else
            grant = !rr_last_q;
`endif
        else
            grant = s1_AWVALID;

        aw_ok      = active && !full;
        m_AWVALID  = aw_ok && (grant ? s1_AWVALID : s0_AWVALID);
        m_AWADDR   = m_AWVALID ? (grant ? s1_AWADDR : s0_AWADDR) : '0;
        m_AWLEN    = m_AWVALID ? (grant ? s1_AWLEN : s0_AWLEN) : '0;
        s0_AWREADY = aw_ok && m_AWREADY && !grant;
        s1_AWREADY = aw_ok && m_AWREADY && grant;
        aw_fire    = m_AWVALID && m_AWREADY;

        head      = order_q[rd_ptr_q];
        w_ok      = active && (count_q != '0);
        m_WVALID  = w_ok && (head ? s1_WVALID : s0_WVALID);
        m_WDATA   = m_WVALID ? (head ? s1_WDATA : s0_WDATA) : '0;
        m_WSTRB   = m_WVALID ? (head ? s1_WSTRB : s0_WSTRB) : '0;
        m_WLAST   = m_WVALID && (head ? s1_WLAST : s0_WLAST);
        s0_WREADY = w_ok && m_WREADY && !head;
        s1_WREADY = w_ok && m_WREADY && head;
        w_pop     = m_WVALID && m_WREADY && m_WLAST;
    end

    always_comb begin
        rr_last_d   = rr_last_q;
        lock_d      = lock_q;
        locked_id_d = locked_id_q;
        order_d     = order_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        if (aw_fire) begin
            rr_last_d         = grant;
            lock_d            = 1'b0;
            order_d[wr_ptr_q] = grant;
            wr_ptr_d          = ptr_next(wr_ptr_q);
        end else if (m_AWVALID) begin
            lock_d      = 1'b1;
            locked_id_d = grant;
        end
        if (w_pop)
            rd_ptr_d = ptr_next(rd_ptr_q);
        count_d = count_q + PW'(aw_fire) - PW'(w_pop);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_last_q   <= 1'b1;
            lock_q      <= 1'b0;
            locked_id_q <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else if (clk_en) begin
            rr_last_q   <= rr_last_d;
            lock_q      <= lock_d;
            locked_id_q <= locked_id_d;
            order_q     <= order_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end
endmodule

// File: tb/tb_blk_1f839b.sv
// Randomized bench for blk_1f839b: queue-based arbitration/ordering model plus directed scenarios.
module tb_blk_1f839b;
    localparam int AW = 32, DW = 32, SW = 4, MAXR = 4;
`ifdef WR_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst, ce;
    logic [AW-1:0] aw_addr [2];
    logic [7:0]    aw_len  [2];
    logic          aw_valid[2];
    logic [DW-1:0] w_data  [2];
    logic [SW-1:0] w_strb  [2];
    logic          w_last  [2];
    logic          w_valid [2];
    logic          m_awready, m_wready;
    logic          s0_awr, s1_awr, s0_wr, s1_wr;
    logic [AW-1:0] m_AWADDR;
    logic [7:0]    m_AWLEN;
    logic          m_AWVALID, m_WLAST, m_WVALID;
    logic [DW-1:0] m_WDATA;
    logic [SW-1:0] m_WSTRB;
    logic [2:0]    pending;

    int nvec = 0, nerr = 0;

    // reference model state
    bit md_rr_last, md_lock;
    int md_lid;
    int q[$];
    // per-cycle observations and events
    bit obs_awvalid, obs_wvalid, obs_any, obs_awr0;
    logic [AW-1:0] obs_awaddr;
    int obs_pending, ev_aw_id, ev_w_id;
    bit ev_w_last;
    // requester driver state
    int nb[2], cur_len[2], wbeat[2], wq[2][$];
    int fixed_len, pa, pw, pv, pce;
    int aw_log[$], w_log[$], wv_log[$];

    blk_1f839b #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAXREQS(MAXR)) dut (
        .clk(clk), .reset(rst), .clk_en(ce),
        .s0_AWADDR(aw_addr[0]), .s0_AWLEN(aw_len[0]), .s0_AWVALID(aw_valid[0]), .s0_AWREADY(s0_awr),
        .s0_WDATA(w_data[0]), .s0_WSTRB(w_strb[0]), .s0_WLAST(w_last[0]), .s0_WVALID(w_valid[0]), .s0_WREADY(s0_wr),
        .s1_AWADDR(aw_addr[1]), .s1_AWLEN(aw_len[1]), .s1_AWVALID(aw_valid[1]), .s1_AWREADY(s1_awr),
        .s1_WDATA(w_data[1]), .s1_WSTRB(w_strb[1]), .s1_WLAST(w_last[1]), .s1_WVALID(w_valid[1]), .s1_WREADY(s1_wr),
        .m_AWADDR(m_AWADDR), .m_AWLEN(m_AWLEN), .m_AWVALID(m_AWVALID), .m_AWREADY(m_awready),
        .m_WDATA(m_WDATA), .m_WSTRB(m_WSTRB), .m_WLAST(m_WLAST), .m_WVALID(m_WVALID), .m_WREADY(m_wready),
        .pending(pending)
    );

    always #5 clk = ~clk;

    // One clock: compare outputs against the model at negedge, then advance the model at posedge.
    task automatic step();
        int g, h, hh;
        bit act, full, awv, wv;
        @(negedge clk);
        act  = !rst && ce;
        full = q.size() >= MAXR;
        if (md_lock) g = md_lid;
        else if (aw_valid[0] && aw_valid[1]) g = FIXED ? 0 : (md_rr_last ? 0 : 1);
        else g = aw_valid[1] ? 1 : 0;
        awv = act && !full && aw_valid[g];
        h   = (act && q.size() > 0) ? q[0] : -1;
        hh  = (h < 0) ? 0 : h;
        wv  = (h >= 0) && w_valid[hh];

        nvec++; if (m_AWVALID !== awv) begin nerr++; $display("FAIL awvalid: got %b expected %b", m_AWVALID, awv); end
        nvec++; if (m_AWADDR !== (awv ? aw_addr[g] : '0)) begin nerr++; $display("FAIL awaddr: got %h expected %h", m_AWADDR, awv ? aw_addr[g] : '0); end
        nvec++; if (m_AWLEN !== (awv ? aw_len[g] : 8'd0)) begin nerr++; $display("FAIL awlen: got %h expected %h", m_AWLEN, awv ? aw_len[g] : 8'd0); end
        if (!act || awv) begin
            nvec++;
            if (s0_awr !== (awv && g == 0 && m_awready) || s1_awr !== (awv && g == 1 && m_awready)) begin
                nerr++; $display("FAIL awready: got %b%b expected %b%b", s1_awr, s0_awr, awv && g == 1 && m_awready, awv && g == 0 && m_awready);
            end
        end else begin
            nvec++;
            if (((s0_awr && aw_valid[0]) || (s1_awr && aw_valid[1])) !== 1'b0) begin
                nerr++; $display("FAIL aw_no_grant: got handshake s1/s0=%b%b expected none", s1_awr, s0_awr);
            end
        end
        nvec++; if (m_WVALID !== wv) begin nerr++; $display("FAIL wvalid: got %b expected %b", m_WVALID, wv); end
        nvec++; if (m_WDATA !== (wv ? w_data[hh] : '0)) begin nerr++; $display("FAIL wdata: got %h expected %h", m_WDATA, wv ? w_data[hh] : '0); end
        nvec++; if (m_WSTRB !== (wv ? w_strb[hh] : '0)) begin nerr++; $display("FAIL wstrb: got %h expected %h", m_WSTRB, wv ? w_strb[hh] : '0); end
        nvec++; if (m_WLAST !== (wv && w_last[hh])) begin nerr++; $display("FAIL wlast: got %b expected %b", m_WLAST, wv && w_last[hh]); end
        nvec++;
        if (s0_wr !== (h == 0 && m_wready) || s1_wr !== (h == 1 && m_wready)) begin
            nerr++; $display("FAIL wready: got %b%b expected %b%b", s1_wr, s0_wr, h == 1 && m_wready, h == 0 && m_wready);
        end
        nvec++; if (pending !== 3'(q.size())) begin nerr++; $display("FAIL pending: got %0d expected %0d", pending, q.size()); end

        obs_awvalid = m_AWVALID; obs_awaddr = m_AWADDR; obs_wvalid = m_WVALID;
        obs_pending = int'(pending); obs_awr0 = s0_awr;
        obs_any = m_AWVALID | m_WVALID | s0_awr | s1_awr | s0_wr | s1_wr;

        @(posedge clk);
        ev_aw_id = -1; ev_w_id = -1; ev_w_last = 1'b0;
        if (rst) begin
            q.delete(); md_rr_last = 1'b1; md_lock = 1'b0;
        end else if (ce) begin
            if (wv && m_wready) begin
                ev_w_id = h; ev_w_last = w_last[hh];
                if (w_last[hh]) void'(q.pop_front());
            end
            if (awv && m_awready) begin
                md_rr_last = (g == 1); md_lock = 1'b0; q.push_back(g); ev_aw_id = g;
            end else if (awv) begin
                md_lock = 1'b1; md_lid = g;
            end
        end
        #1;
    endtask

    task automatic load(input int n);
        cur_len[n] = (fixed_len >= 0) ? fixed_len : $urandom_range(0, 3);
        aw_addr[n] = $urandom;
        aw_len[n]  = 8'(cur_len[n]);
    endtask

    task automatic drv_clear();
        for (int n = 0; n < 2; n++) begin
            nb[n] = 0; wbeat[n] = 0; wq[n].delete();
            aw_valid[n] = 1'b0; w_valid[n] = 1'b0; w_last[n] = 1'b0;
            aw_addr[n] = '0; aw_len[n] = '0; w_data[n] = '0; w_strb[n] = '0;
        end
        aw_log.delete(); w_log.delete(); wv_log.delete();
        fixed_len = -1; pa = 100; pw = 100; pv = 100; pce = 100;
        m_awready = 1'b0; m_wready = 1'b0; ce = 1'b1;
    endtask

    task automatic drive();
        int L;
        for (int n = 0; n < 2; n++) begin
            aw_valid[n] = nb[n] > 0;
            if (nb[n] == 0) begin aw_addr[n] = $urandom; aw_len[n] = 8'($urandom); end
            L = (wq[n].size() > 0) ? wq[n][0] : ((nb[n] > 0) ? cur_len[n] : -1);
            w_data[n] = $urandom; w_strb[n] = 4'($urandom);
            if (L >= 0 && $urandom_range(0, 99) < pv) begin
                w_valid[n] = 1'b1; w_last[n] = (wbeat[n] == L);
            end else begin
                w_valid[n] = 1'b0; w_last[n] = 1'($urandom);
            end
        end
        m_awready = $urandom_range(0, 99) < pa;
        m_wready  = $urandom_range(0, 99) < pw;
        ce        = $urandom_range(0, 99) < pce;
    endtask

    task automatic update();
        int n;
        wv_log.push_back(int'(obs_wvalid));
        if (ev_w_id >= 0) begin
            n = ev_w_id; w_log.push_back(n);
            if (ev_w_last) begin void'(wq[n].pop_front()); wbeat[n] = 0; end
            else wbeat[n]++;
        end
        if (ev_aw_id >= 0) begin
            n = ev_aw_id; aw_log.push_back(n);
            wq[n].push_back(cur_len[n]); nb[n]--;
            if (nb[n] > 0) load(n);
        end
    endtask

    task automatic run_traffic(input int bound, input string name);
        int cyc = 0;
        while ((nb[0] + nb[1] + wq[0].size() + wq[1].size()) > 0 && cyc < bound) begin
            drive(); step(); update(); cyc++;
        end
        nvec++;
        if (cyc >= bound) begin nerr++; $display("FAIL %s_timeout: got %0d cycles expected < %0d", name, cyc, bound); end
    endtask

    task automatic do_reset();
        drv_clear();
        rst = 1'b1; step(); rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        nvec++; if (obs_any !== 1'b0) begin nerr++; $display("FAIL reset_outputs: got %b expected 0", obs_any); end
        step();
        nvec++; if (obs_pending !== 0) begin nerr++; $display("FAIL reset_pending: got %0d expected 0", obs_pending); end
        aw_valid[0] = 1'b1; aw_valid[1] = 1'b1; aw_addr[0] = 32'h100; aw_addr[1] = 32'h200; m_awready = 1'b1;
        step();
        nvec++; if (ev_aw_id !== 0) begin nerr++; $display("FAIL reset_first_tie: got %0d expected 0", ev_aw_id); end
    endtask

    task automatic test_round_robin();
        int e;
        do_reset();
        fixed_len = 3; nb[0] = 4; nb[1] = 4; load(0); load(1);
        run_traffic(200, "rr");
        nvec++; if (aw_log.size() !== 8) begin nerr++; $display("FAIL rr_aw_count: got %0d expected 8", aw_log.size()); end
        nvec++; if (w_log.size() !== 32) begin nerr++; $display("FAIL rr_w_count: got %0d expected 32", w_log.size()); end
        for (int i = 0; i < 8 && i < aw_log.size(); i++) begin
            e = FIXED ? (i < 4 ? 0 : 1) : (i % 2);
            nvec++; if (aw_log[i] !== e) begin nerr++; $display("FAIL rr_grant[%0d]: got %0d expected %0d", i, aw_log[i], e); end
        end
        for (int i = 0; i < 32 && i < w_log.size(); i++) begin
            e = FIXED ? (i < 16 ? 0 : 1) : ((i / 4) % 2);
            nvec++; if (w_log[i] !== e) begin nerr++; $display("FAIL rr_wbeat[%0d]: got %0d expected %0d", i, w_log[i], e); end
        end
    endtask

    task automatic test_lock();
        do_reset();
        aw_valid[1] = 1'b1; aw_addr[1] = 32'hA111_0001; aw_len[1] = 8'd2; m_awready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i == 1) begin aw_valid[0] = 1'b1; aw_addr[0] = 32'hB000_0000; aw_len[0] = 8'd1; end
            step();
            nvec++;
            if (obs_awaddr !== 32'hA111_0001 || !obs_awvalid) begin
                nerr++; $display("FAIL lock_hold[%0d]: got %h/%b expected a1110001/1", i, obs_awaddr, obs_awvalid);
            end
        end
        m_awready = 1'b1; step();
        nvec++; if (ev_aw_id !== 1) begin nerr++; $display("FAIL lock_handshake: got %0d expected 1", ev_aw_id); end
        aw_valid[1] = 1'b0; step();
        nvec++; if (ev_aw_id !== 0 || obs_awaddr !== 32'hB000_0000) begin
            nerr++; $display("FAIL lock_next: got id %0d addr %h expected 0 b0000000", ev_aw_id, obs_awaddr);
        end
    endtask

    task automatic test_full();
        do_reset();
        m_awready = 1'b1; m_wready = 1'b1; aw_valid[0] = 1'b1; aw_len[0] = 8'd0;
        for (int i = 0; i < 4; i++) begin
            aw_addr[0] = 32'(i); step();
            nvec++; if (ev_aw_id !== 0) begin nerr++; $display("FAIL full_fill[%0d]: got %0d expected 0", i, ev_aw_id); end
        end
        aw_addr[0] = 32'd4; step();
        nvec++; if (obs_pending !== 4 || obs_awr0 !== 1'b0 || ev_aw_id !== -1) begin
            nerr++; $display("FAIL full_block: got pending %0d awready %b id %0d expected 4 0 -1", obs_pending, obs_awr0, ev_aw_id);
        end
        w_valid[0] = 1'b1; w_last[0] = 1'b1; w_data[0] = 32'hDEAD_BEEF; w_strb[0] = 4'hF; step();
        nvec++; if (ev_aw_id !== -1 || ev_w_id !== 0) begin
            nerr++; $display("FAIL full_pop_same: got aw %0d w %0d expected -1 0", ev_aw_id, ev_w_id);
        end
        w_valid[0] = 1'b0; step();
        nvec++; if (obs_pending !== 3 || ev_aw_id !== 0) begin
            nerr++; $display("FAIL full_after_pop: got pending %0d aw %0d expected 3 0", obs_pending, ev_aw_id);
        end
    endtask

    task automatic test_back_to_back();
        int exp_wv[5] = '{0, 1, 1, 1, 1};
        do_reset();
        fixed_len = 1; nb[0] = 2; load(0);
        run_traffic(50, "b2b");
        nvec++; if (wv_log.size() !== 5) begin nerr++; $display("FAIL b2b_len: got %0d expected 5", wv_log.size()); end
        for (int i = 0; i < 5 && i < wv_log.size(); i++) begin
            nvec++; if (wv_log[i] !== exp_wv[i]) begin nerr++; $display("FAIL b2b_wvalid[%0d]: got %0d expected %0d", i, wv_log[i], exp_wv[i]); end
        end
    endtask

    task automatic test_reset_mid();
        int cyc = 0;
        do_reset();
        fixed_len = 7; nb[0] = 1; load(0);
        while (!(wq[0].size() > 0 && wbeat[0] == 2) && cyc < 40) begin drive(); step(); update(); cyc++; end
        nvec++; if (cyc >= 40) begin nerr++; $display("FAIL rmid_timeout: got %0d expected < 40", cyc); end
        drive(); rst = 1'b1; step(); rst = 1'b0;
        nvec++; if (obs_any !== 1'b0) begin nerr++; $display("FAIL rmid_outputs: got %b expected 0", obs_any); end
        drv_clear();
        aw_valid[0] = 1'b1; aw_valid[1] = 1'b1; aw_addr[0] = 32'h55; aw_addr[1] = 32'h66; m_awready = 1'b1;
        step();
        nvec++; if (obs_pending !== 0 || ev_aw_id !== 0) begin
            nerr++; $display("FAIL rmid_after: got pending %0d id %0d expected 0 0", obs_pending, ev_aw_id);
        end
    endtask

    task automatic test_random();
        do_reset();
        pa = 70; pw = 70; pv = 70; pce = 85;
        nb[0] = 40; nb[1] = 40; load(0); load(1);
        run_traffic(4000, "rand");
        nvec++; if (aw_log.size() !== 80) begin nerr++; $display("FAIL rand_aw_count: got %0d expected 80", aw_log.size()); end
    endtask

    initial begin
        drv_clear();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_round_robin();
        test_lock();
        test_full();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
